mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide: rst  in  1  one clock; reset is synchronous and active-high.
REQ-003 SHALL provide: inAluOut  in  `DataPath (32)  ALU result / effective address from execute register.
REQ-004 SHALL provide: inWrData  in  `DataPath (32)  store data.
REQ-005 SHALL provide: inIsLoadInsn, inIsStoreInsn, inRgWrEnable  in  1 each  instruction class / register-write flags.
REQ-006 SHALL provide: inWrRg  in  `RegNumPath (5)  destination register number.
REQ-007 SHALL provide: flush  in  1  kill the instruction currently presented on the in* inputs.
REQ-008 SHALL provide: stallOut  out  1  upstream holds its register contents while high.
REQ-009 SHALL provide: dmemReq, dmemWe  out  1 each; dmemAddr, dmemWrData  out  32 each  data-memory request.
REQ-010 SHALL provide: dmemAck  in  1; dmemRdData  in  32  data-memory completion and read data.
REQ-011 SHALL provide: outRgWrEnable  out  1; outWrRg  out  5; outWrData  out  32; outMisalign  out  1  writeback register.

Function
REQ-012 SHALL treat an input as a memory op when (inIsLoadInsn|inIsStoreInsn) and !flush; a flushed input SHALL be handled as a bubble (all flags 0).
REQ-013 SHALL implement FSM states IDLE and ACCESS.
REQ-014 IDLE, non-memory op: writeback register SHALL load inRgWrEnable/inWrRg/inAluOut next edge; latency 1 cycle; stallOut=0.
REQ-015 IDLE, memory op, inAluOut[1:0]==0: SHALL latch address, store data and dmemWe=inIsStoreInsn, go to ACCESS; stallOut=1 this cycle; writeback register SHALL load a bubble.
REQ-016 IDLE, memory op, inAluOut[1:0]!=0: SHALL issue no request, load writeback register with outRgWrEnable=0 and outMisalign=1 for one cycle, stay IDLE, stallOut=0.
REQ-017 ACCESS: dmemReq SHALL be 1, with dmemAddr/dmemWrData/dmemWe stable until the ack cycle.
REQ-018 ACCESS, dmemAck=0: stallOut=1; writeback register SHALL load a bubble.
REQ-019 ACCESS, dmemAck=1: stallOut=0; next edge SHALL write outWrData=dmemRdData (load) and outRgWrEnable=latched flag (store: 0), return to IDLE, and dmemReq SHALL be 0 next cycle.
REQ-020 Minimum memory-op latency SHALL be 2 cycles (launch + ack); dmemAck while IDLE SHALL be ignored.
REQ-021 flush during ACCESS SHALL NOT abort the in-flight access.
REQ-022 outMisalign SHALL be 0 for every writeback entry other than REQ-016.

Reset
REQ-023 rst high SHALL force IDLE at the next edge and clear dmemReq, dmemWe, dmemAddr, dmemWrData, outRgWrEnable, outWrRg, outWrData and outMisalign to 0.
REQ-024 rst asserted during ACCESS SHALL drop the request without waiting for dmemAck.
REQ-025 stallOut SHALL be 0 in the cycle after reset while IDLE with bubble inputs.

Structure
REQ-026 `DataPath, `RegNumPath, the FSM state encoding and the alignment mask SHALL live in the shared types package.
REQ-027 The writeback register SHALL be the sub-module mem_wb_pipe_reg (load, bubble and reset controls); the FSM SHALL stay in mem_access_stage.

Verification
REQ-028 Add with inRgWrEnable=1, inWrRg=3, inAluOut=0x10 -> one cycle later outRgWrEnable=1, outWrRg=3, outWrData=0x10, stallOut never high.
REQ-029 Load at 0x100, dmemAck 3 cycles after dmemReq, dmemRdData=0xDEADBEEF -> stallOut high 4 cycles, then outWrData=0xDEADBEEF.
REQ-030 Store at 0x104 with data 0x55, immediate ack -> dmemWe=1, dmemAddr=0x104, dmemWrData=0x55 for one cycle; outRgWrEnable=0.
REQ-031 Load at 0x102 -> no dmemReq; outMisalign=1 for one cycle, outRgWrEnable=0.
REQ-032 Load with flush=1 -> no dmemReq, bubble written; flush pulse in ACCESS -> access completes normally.
REQ-033 rst pulse in ACCESS before ack -> dmemReq=0 and state IDLE next cycle; late ack ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths, FSM encoding and alignment mask for the memory-access stage
package mem_access_stage_pkg;

    localparam int DataPath   = 32;
    localparam int RegNumPath = 5;

    localparam logic [1:0] AlignMask = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } accessStateT;

    function automatic logic isWordAligned(input logic [DataPath-1:0] addr);
        return (addr[1:0] & AlignMask) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - writeback pipeline register with load, bubble and reset controls
module mem_wb_pipe_reg
    import mem_access_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  bubble,
    input  logic                  rgWrEnable,
    input  logic [RegNumPath-1:0] wrRg,
    input  logic [DataPath-1:0]   wrData,
    input  logic                  misalign,
    output logic                  outRgWrEnable,
    output logic [RegNumPath-1:0] outWrRg,
    output logic [DataPath-1:0]   outWrData,
    output logic                  outMisalign
);

    // Bubble takes priority over load so a stalled stage can never leak a stale write.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            outRgWrEnable <= 1'b0;
            outWrRg       <= '0;
            outWrData     <= '0;
            outMisalign   <= 1'b0;
        end else if (load) begin
            outRgWrEnable <= rgWrEnable;
            outWrRg       <= wrRg;
            outWrData     <= wrData;
            outMisalign   <= misalign;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage: issues data-memory requests and stalls until ack
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DataPath-1:0]   inAluOut,
    input  logic [DataPath-1:0]   inWrData,
    input  logic                  inIsLoadInsn,
    input  logic                  inIsStoreInsn,
    input  logic                  inRgWrEnable,
    input  logic [RegNumPath-1:0] inWrRg,
    input  logic                  flush,
    output logic                  stallOut,
    output logic                  dmemReq,
    output logic                  dmemWe,
    output logic [DataPath-1:0]   dmemAddr,
    output logic [DataPath-1:0]   dmemWrData,
    input  logic                  dmemAck,
    input  logic [DataPath-1:0]   dmemRdData,
    output logic                  outRgWrEnable,
    output logic [RegNumPath-1:0] outWrRg,
    output logic [DataPath-1:0]   outWrData,
    output logic                  outMisalign
);

    accessStateT state, nextState;

    logic                  weQ;
    logic                  rgWrEnQ;
    logic [RegNumPath-1:0] wrRgQ;
    logic [DataPath-1:0]   addrQ;
    logic [DataPath-1:0]   wrDataQ;

    logic                  isMemOp;
    logic                  launch;
    logic                  wbLoad;
    logic                  wbBubble;
    logic                  wbRgWrEnable;
    logic [RegNumPath-1:0] wbWrRg;
    logic [DataPath-1:0]   wbWrData;
    logic                  wbMisalign;

    assign isMemOp = (inIsLoadInsn || inIsStoreInsn) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Request fields are captured once at launch and held for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            weQ     <= 1'b0;
            rgWrEnQ <= 1'b0;
            wrRgQ   <= '0;
            addrQ   <= '0;
            wrDataQ <= '0;
        end else if (launch) begin
            weQ     <= inIsStoreInsn;
            rgWrEnQ <= inRgWrEnable;
            wrRgQ   <= inWrRg;
            addrQ   <= inAluOut;
            wrDataQ <= inWrData;
        end
    end

    always_comb begin
        nextState    = state;
        launch       = 1'b0;
        stallOut     = 1'b0;
        wbLoad       = 1'b0;
        wbBubble     = 1'b0;
        wbRgWrEnable = 1'b0;
        wbWrRg       = '0;
        wbWrData     = '0;
        wbMisalign   = 1'b0;
        case (state)
            IDLE: begin
                if (isMemOp && isWordAligned(inAluOut)) begin
                    launch    = 1'b1;
                    stallOut  = 1'b1;
                    wbBubble  = 1'b1;
                    nextState = ACCESS;
                end else if (isMemOp) begin
                    wbLoad     = 1'b1;
                    wbWrRg     = inWrRg;
                    wbWrData   = inAluOut;
                    wbMisalign = 1'b1;
                end else if (flush) begin
                    wbBubble = 1'b1;
                end else begin
                    wbLoad       = 1'b1;
                    wbRgWrEnable = inRgWrEnable;
                    wbWrRg       = inWrRg;
                    wbWrData     = inAluOut;
                end
            end
            ACCESS: begin
                // The in* inputs still hold the in-flight op here, so flush is ignored.
                if (dmemAck) begin
                    wbLoad       = 1'b1;
                    wbRgWrEnable = rgWrEnQ && !weQ;
                    wbWrRg       = wrRgQ;
                    wbWrData     = dmemRdData;
                    nextState    = IDLE;
                end else begin
                    stallOut = 1'b1;
                    wbBubble = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign dmemReq    = (state == ACCESS);
    assign dmemWe     = (state == ACCESS) && weQ;
    assign dmemAddr   = addrQ;
    assign dmemWrData = wrDataQ;

    mem_wb_pipe_reg uWbReg (
        .clk           (clk),
        .rst           (rst),
        .load          (wbLoad),
        .bubble        (wbBubble),
        .rgWrEnable    (wbRgWrEnable),
        .wrRg          (wbWrRg),
        .wrData        (wbWrData),
        .misalign      (wbMisalign),
        .outRgWrEnable (outRgWrEnable),
        .outWrRg       (outWrRg),
        .outWrData     (outWrData),
        .outMisalign   (outMisalign)
    );

endmodule
